uart_mmio: RTL and testbench

- Memory-mapped console device sitting directly downstream of the core's data port, alongside ram_top.
- Decodes loads and stores aimed at the UART window and buffers transmitted bytes in a TX FIFO.
- Drains the FIFO onto the simulation uart_out interface at a paced rate.
- Serves RX reads from the simulation uart_in interface and exposes a line-status register, so software polls it as an ns16550-style device.

---
 rtl/uart_mmio.sv | 102 ++++++++++
 tb/tb_uart_mmio.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio.sv
// Memory-mapped console UART: decodes core loads and stores in an 8-byte window,
// buffers TX bytes in a FIFO drained at a paced rate, and serves RX and line-status reads.
module uart_mmio #(
  parameter logic [63:0] UART_BASE  = 64'h0000_0000_1000_0000,
  parameter int          FIFO_DEPTH = 16,
  parameter int          TX_DIV     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [63:0] data_addr,
  input  logic [7:0]  write_data,
  output logic        hit,
  output logic [63:0] read_data,
  output logic        tx_full,
  output logic [15:0] drop_cnt,
  output logic        uart_out_valid,
  output logic [7:0]  uart_out_ch,
  output logic        uart_in_valid,
  input  logic [7:0]  uart_in_ch
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [DW-1:0] DIV_LOAD = DW'(TX_DIV - 1);

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [DW-1:0] div_cnt;
  logic [2:0]    off;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          tx_idle;

  assign off      = data_addr[2:0];
  assign hit      = (data_addr[63:3] == UART_BASE[63:3]);
  assign push_req = hit && mem_write && (off == 3'd0);
  assign pop      = (count != '0) && (div_cnt == '0);
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push_ok  = push_req && ((count < DEPTH_C) || pop);
  assign tx_idle  = (count == '0) && (div_cnt == '0);

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop)      count_nxt = count + CW'(1);
    else if (!push_ok && pop) count_nxt = count - CW'(1);
  end

  // RX handshake: uart_in_valid is a same-cycle request; the host must
  // present uart_in_ch in that cycle, there is no ready/backpressure.
  assign uart_in_valid = hit && mem_read && (off == 3'd0);

  always_comb begin
    read_data = 64'd0;
    if (hit && mem_read) begin
      case (off)
        3'd0:    read_data = {56'd0, uart_in_ch};
        3'd5:    read_data = {56'd0, 1'b0, tx_idle, ~tx_full, 4'd0, 1'b1};
        default: read_data = 64'd0;
      endcase
    end
  end

  // Storage carries no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (rst && push_ok) fifo_mem[wr_ptr] <= write_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      div_cnt        <= '0;
      tx_full        <= 1'b0;
      drop_cnt       <= 16'd0;
      uart_out_valid <= 1'b0;
      uart_out_ch    <= 8'd0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (push_req && !push_ok && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      count          <= count_nxt;
      tx_full        <= (count_nxt == DEPTH_C);
      uart_out_valid <= pop;
      if (pop) begin
        rd_ptr      <= rd_ptr + AW'(1);
        uart_out_ch <= fifo_mem[rd_ptr];
        div_cnt     <= DIV_LOAD;
      end else if (div_cnt != '0) begin
        div_cnt <= div_cnt - DW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Bench for uart_mmio: a queue-and-timestamp reference model predicts every
// output byte, its cycle, tx_full, drop count and all load responses.
module tb_uart_mmio;

  localparam logic [63:0] BASE  = 64'h0000_0000_1000_0000;
  localparam int          DEPTH = 16;
  localparam int          DIV   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_write, mem_read;
  logic [63:0] data_addr;
  logic [7:0]  write_data;
  logic        hit;
  logic [63:0] read_data;
  logic        tx_full;
  logic [15:0] drop_cnt;
  logic        uart_out_valid;
  logic [7:0]  uart_out_ch;
  logic        uart_in_valid;
  logic [7:0]  uart_in_ch;

  uart_mmio #(.UART_BASE(BASE), .FIFO_DEPTH(DEPTH), .TX_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .mem_write(mem_write), .mem_read(mem_read),
    .data_addr(data_addr), .write_data(write_data), .hit(hit),
    .read_data(read_data), .tx_full(tx_full), .drop_cnt(drop_cnt),
    .uart_out_valid(uart_out_valid), .uart_out_ch(uart_out_ch),
    .uart_in_valid(uart_in_valid), .uart_in_ch(uart_in_ch)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: bytes waiting, cycle of the last departure, drops.
  logic [7:0] mq[$];
  int         cyc      = 0;
  int         last_pop = -1000;
  int         m_drop   = 0;

  // Scoreboard: expected/observed output bytes with the cycle they appear.
  logic [7:0] exp_q[$];
  int         exp_t[$];
  logic [7:0] obs_q[$];
  int         obs_t[$];
  logic       exp_full_q[$];
  logic       obs_full_q[$];

  logic        obs_hit, obs_iv, exp_hit, exp_iv;
  logic [63:0] obs_rdata, exp_rdata;

  task automatic clear_sb();
    exp_q.delete(); exp_t.delete(); obs_q.delete(); obs_t.delete();
    exp_full_q.delete(); obs_full_q.delete();
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [63:0] addr,
                       input logic [7:0] wd, input logic [7:0] inch);
    logic       m_pop, m_push_req, m_push_ok, m_idle;
    logic [7:0] head;
    mem_write = wr; mem_read = rd; data_addr = addr; write_data = wd; uart_in_ch = inch;
    #1;
    obs_hit = hit; obs_rdata = read_data; obs_iv = uart_in_valid;
    exp_hit   = (addr[63:3] == BASE[63:3]);
    exp_iv    = exp_hit && rd && (addr[2:0] == 3'd0);
    m_idle    = (mq.size() == 0) && (cyc - last_pop >= DIV);
    exp_rdata = 64'd0;
    if (exp_hit && rd && addr[2:0] == 3'd0) exp_rdata = {56'd0, inch};
    if (exp_hit && rd && addr[2:0] == 3'd5)
      exp_rdata = 64'h01 | (m_idle ? 64'h40 : 64'h0) | ((mq.size() != DEPTH) ? 64'h20 : 64'h0);
    m_pop      = (mq.size() != 0) && (cyc - last_pop >= DIV);
    head       = m_pop ? mq[0] : 8'd0;
    m_push_req = exp_hit && wr && (addr[2:0] == 3'd0);
    m_push_ok  = m_push_req && ((mq.size() < DEPTH) || m_pop);
    @(posedge clk);
    #1;
    if (m_pop) begin
      void'(mq.pop_front());
      last_pop = cyc;
      exp_q.push_back(head);
      exp_t.push_back(cyc + 1);
    end
    if (m_push_ok) mq.push_back(wd);
    else if (m_push_req && m_drop < 65535) m_drop++;
    cyc++;
    if (uart_out_valid) begin
      obs_q.push_back(uart_out_ch);
      obs_t.push_back(cyc);
    end
    obs_full_q.push_back(tx_full);
    exp_full_q.push_back(mq.size() == DEPTH);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 64'd0, 8'd0, 8'd0);
  endtask

  task automatic do_reset();
    mem_write = 1'b0; mem_read = 1'b0; data_addr = 64'd0; write_data = 8'd0; uart_in_ch = 8'd0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    mq.delete(); last_pop = -1000; m_drop = 0; cyc++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL reset_tx_full got %0b want 0", tx_full); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
    checks++; if (uart_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", uart_out_valid); end
    checks++; if (uart_out_ch !== 8'd0) begin errors++; $display("FAIL reset_ch got %h want 00", uart_out_ch); end
    drive(1'b0, 1'b1, BASE + 64'd5, 8'd0, 8'd0);
    checks++; if (obs_rdata !== 64'h61) begin errors++; $display("FAIL reset_lsr got %h want 61", obs_rdata); end
  endtask

  task automatic test_single();
    int n;
    clear_sb();
    n = cyc;
    drive(1'b1, 1'b0, BASE, 8'h41, 8'd0);
    idle(6);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== 8'h41 || obs_t[0] != n + 2) begin
      errors++;
      $display("FAIL single_latency got %0d pulses first ch %h at %0d want 1 pulse 41 at %0d",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 8'h00, (obs_t.size() > 0) ? obs_t[0] : -1, n + 2);
    end
  endtask

  task automatic test_three();
    int n;
    logic [7:0] want [3];
    want[0] = 8'h61; want[1] = 8'h62; want[2] = 8'h63;
    clear_sb();
    n = cyc;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, BASE, want[i], 8'd0);
    idle(14);
    checks++;
    if (obs_q.size() != 3) begin errors++; $display("FAIL three_count got %0d want 3", obs_q.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_q[i] !== want[i] || obs_t[i] != n + 2 + 4 * i) begin
          errors++;
          $display("FAIL three_pulse%0d got %h at %0d want %h at %0d", i, obs_q[i], obs_t[i], want[i], n + 2 + 4 * i);
        end
      end
    end
  endtask

  task automatic test_burst(input int nstores);
    clear_sb();
    for (int i = 0; i < nstores; i++) drive(1'b1, 1'b0, BASE, 8'($urandom_range(0, 255)), 8'd0);
    idle(DEPTH * DIV + 10);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL burst%0d_count got %0d want %0d", nstores, obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i] || obs_t[i] != exp_t[i]) begin
          errors++;
          $display("FAIL burst%0d_byte%0d got %h at %0d want %h at %0d", nstores, i, obs_q[i], obs_t[i], exp_q[i], exp_t[i]);
        end
        if (i > 0) begin
          checks++;
          if (obs_t[i] - obs_t[i-1] < DIV) begin
            errors++; $display("FAIL burst%0d_gap%0d got %0d want >= %0d", nstores, i, obs_t[i] - obs_t[i-1], DIV);
          end
        end
      end
    end
    for (int i = 0; i < obs_full_q.size(); i++) begin
      checks++;
      if (obs_full_q[i] !== exp_full_q[i]) begin
        errors++; $display("FAIL burst%0d_full%0d got %0b want %0b", nstores, i, obs_full_q[i], exp_full_q[i]);
      end
    end
    checks++;
    if (drop_cnt !== 16'(m_drop)) begin errors++; $display("FAIL burst%0d_drop got %0d want %0d", nstores, drop_cnt, m_drop); end
  endtask

  task automatic test_rx();
    logic [7:0] ch;
    drive(1'b0, 1'b1, BASE, 8'd0, 8'h7A);
    checks++; if (obs_iv !== 1'b1 || obs_rdata !== 64'h7A) begin
      errors++; $display("FAIL rx_7a got iv %0b data %h want iv 1 data 7a", obs_iv, obs_rdata); end
    drive(1'b0, 1'b1, BASE + 64'd1, 8'd0, 8'h7A);
    checks++; if (obs_iv !== 1'b0 || obs_rdata !== 64'd0) begin
      errors++; $display("FAIL rx_off1 got iv %0b data %h want iv 0 data 0", obs_iv, obs_rdata); end
    for (int i = 0; i < 8; i++) begin
      ch = 8'($urandom_range(0, 255));
      drive(1'b0, 1'b1, BASE, 8'd0, ch);
      checks++; if (obs_iv !== exp_iv || obs_rdata !== exp_rdata) begin
        errors++; $display("FAIL rx_rand got iv %0b data %h want iv %0b data %h", obs_iv, obs_rdata, exp_iv, exp_rdata); end
    end
  endtask

  task automatic test_decode();
    logic [15:0] drop0;
    clear_sb();
    drop0 = drop_cnt;
    drive(1'b1, 1'b0, BASE + 64'd8, 8'h55, 8'd0);
    checks++; if (obs_hit !== 1'b0) begin errors++; $display("FAIL decode_plus8 got hit %0b want 0", obs_hit); end
    drive(1'b1, 1'b0, BASE + 64'd5, 8'h56, 8'd0);
    checks++; if (obs_hit !== 1'b1) begin errors++; $display("FAIL decode_plus5 got hit %0b want 1", obs_hit); end
    idle(6);
    drive(1'b0, 1'b1, BASE + 64'd5, 8'd0, 8'd0);
    checks++; if (obs_q.size() != 0 || obs_rdata !== 64'h61 || drop_cnt !== drop0) begin
      errors++; $display("FAIL decode_nochange got %0d pulses lsr %h drop %0d want 0 pulses lsr 61 drop %0d",
                         obs_q.size(), obs_rdata, drop_cnt, drop0); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, BASE, 8'(8'hA0 + i), 8'd0);
    idle(2);
    do_reset();
    checks++; if (uart_out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %0b want 0", uart_out_valid); end
    clear_sb();
    drive(1'b0, 1'b1, BASE + 64'd5, 8'd0, 8'd0);
    checks++; if (obs_rdata[6] !== 1'b1 || obs_rdata !== 64'h61) begin
      errors++; $display("FAIL midreset_lsr got %h want 61", obs_rdata); end
    idle(30);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL midreset_quiet got %0d pulses want 0", obs_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a;
    int sel;
    clear_sb();
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 11);
      if (sel < 8)       a = BASE + 64'(sel);
      else if (sel < 10) a = BASE + 64'(8 + $urandom_range(0, 7));
      else               a = {$urandom, $urandom};
      if (sel < 4) a = BASE;
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      checks++;
      if (obs_hit !== exp_hit || obs_iv !== exp_iv || obs_rdata !== exp_rdata) begin
        errors++;
        $display("FAIL b2b_load%0d got hit %0b iv %0b data %h want hit %0b iv %0b data %h",
                 i, obs_hit, obs_iv, obs_rdata, exp_hit, exp_iv, exp_rdata);
      end
    end
    idle(DEPTH * DIV + 10);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i] || obs_t[i] != exp_t[i]) begin
          errors++; $display("FAIL b2b_byte%0d got %h at %0d want %h at %0d", i, obs_q[i], obs_t[i], exp_q[i], exp_t[i]);
        end
      end
    end
    for (int i = 0; i < obs_full_q.size(); i++) begin
      checks++;
      if (obs_full_q[i] !== exp_full_q[i]) begin
        errors++; $display("FAIL b2b_full%0d got %0b want %0b", i, obs_full_q[i], exp_full_q[i]);
      end
    end
    checks++;
    if (drop_cnt !== 16'(m_drop)) begin errors++; $display("FAIL b2b_drop got %0d want %0d", drop_cnt, m_drop); end
  endtask

  initial begin
    rst = 1'b0; mem_write = 1'b0; mem_read = 1'b0; data_addr = 64'd0; write_data = 8'd0; uart_in_ch = 8'd0;
    @(negedge clk);
    do_reset();
    test_reset();
    test_single();
    test_three();
    test_burst(20);
    test_burst(40);
    test_rx();
    test_decode();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
